// File: rtl/abc_input_conditioner_pkg.sv
// Shared types and constants for the ABC switch input conditioner.
package abc_pkg;

    // Per-bit debounce FSM: STABLE when synchronised input matches the output,
    // PENDING while a differing level is being timed.
    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } db_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage : abc_pkg

// File: rtl/abc_input_conditioner_if.sv
// Bundle of the switch inputs and conditioned outputs of the input conditioner.
interface abc_input_conditioner_if;

    logic [2:0] sw;
    logic       A;
    logic       B;
    logic       C;
    logic       abc_changed;

    // Master drives the raw switches and observes the conditioned levels.
    modport master (
        output sw,
        input  A,
        input  B,
        input  C,
        input  abc_changed
    );

    // Slave is the conditioner itself.
    modport slave (
        input  sw,
        output A,
        output B,
        output C,
        output abc_changed
    );

endinterface : abc_input_conditioner_if

// File: rtl/abc_input_conditioner_debounce_bit.sv
// One switch bit: two-flop synchroniser, debounce counter and STABLE/PENDING FSM.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   STABLE  | synchronised input equals the output, counter held at 0
//   PENDING | synchronised input differs, counter timing the new level
module debounce_bit
    import abc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic n_reset,
    input  logic sw_i,
    output logic out_o,
    output logic update_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    db_state_e        state_q;
    db_state_e        state_d;
    logic             out_q;
    logic             out_d;
    logic             update;

    // Synchroniser, counter, FSM and output registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= STABLE;
            out_q   <= 1'b0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // Next-state: time a differing level, drop it on a bounce, commit at terminal count.
    always_comb begin
        cnt_d   = '0;
        state_d = STABLE;
        out_d   = out_q;
        update  = 1'b0;
        if (sync2_q != out_q) begin
            // Terminal count also covers DEBOUNCE_CYCLES == 1, where the first
            // differing clock commits straight from STABLE.
            if (cnt_q == CNT_LAST) begin
                out_d  = sync2_q;
                update = 1'b1;
            end else begin
                state_d = PENDING;
                cnt_d   = (state_q == STABLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_o    = out_q;
    assign update_o = update;

endmodule : debounce_bit

// File: rtl/abc_input_conditioner.sv
// Debounces the three raw switch levels into A, B, C and flags any change.
module abc_input_conditioner
    import abc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic [2:0] sw,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       abc_changed
);

    logic [2:0] deb;
    logic [2:0] upd;
    logic       abc_changed_q;
    logic       abc_changed_d;

    for (genvar i = 0; i < 3; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce_bit (
            .clk     (clk),
            .n_reset (n_reset),
            .sw_i    (sw[i]),
            .out_o   (deb[i]),
            .update_o(upd[i])
        );
    end

    // Any bit committing at this edge raises the change flag at the same edge.
    always_comb begin
        abc_changed_d = |upd;
    end

    // Change-flag register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            abc_changed_q <= 1'b0;
        end else begin
            abc_changed_q <= abc_changed_d;
        end
    end

    assign A           = deb[2];
    assign B           = deb[1];
    assign C           = deb[0];
    assign abc_changed = abc_changed_q;

endmodule : abc_input_conditioner

// File: tb/tb_abc_input_conditioner.sv
// Self-checking bench for abc_input_conditioner with DEBOUNCE_CYCLES = 4.
module tb_abc_input_conditioner;

    localparam int DC = 4;

    logic clk = 1'b0;
    logic n_reset = 1'b0;

    always #5 clk = ~clk;

    abc_input_conditioner_if ifc ();

    abc_input_conditioner #(
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .sw         (ifc.sw),
        .A          (ifc.A),
        .B          (ifc.B),
        .C          (ifc.C),
        .abc_changed(ifc.abc_changed)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    // Reference model: the raw values sampled at recent edges. The output takes
    // a new level once the last DC synchronised samples all agree on it.
    logic [2:0] hist[$];
    logic [2:0] m_out;
    logic       m_chg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DC + 2; i++) hist.push_back(3'b000);
        m_out = 3'b000;
        m_chg = 1'b0;
    endtask

    // Advance one clock, update the model and compare away from the edge.
    task automatic step();
        logic [2:0] nxt;
        @(posedge clk);
        if (!n_reset) begin
            model_reset();
        end else begin
            hist.push_back(ifc.sw);
            if (hist.size() > DC + 2) void'(hist.pop_front());
            // Sample at edge n reaches the FSM at edge n+2: window is hist[0..DC-1].
            nxt = m_out;
            for (int b = 0; b < 3; b++) begin
                logic v;
                logic all_eq;
                v = hist[0][b];
                all_eq = 1'b1;
                for (int i = 0; i < DC; i++) if (hist[i][b] != v) all_eq = 1'b0;
                if (all_eq && v != m_out[b]) nxt[b] = v;
            end
            m_chg = (nxt != m_out);
            m_out = nxt;
        end
        #1;
        check("abc", {ifc.A, ifc.B, ifc.C}, m_out);
        check("abc_changed", ifc.abc_changed, m_chg);
        if (ifc.abc_changed) pulses++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic reset_cycle(input int n_in_reset);
        n_reset = 1'b0;
        #2;
        check("reset_async_abc", {ifc.A, ifc.B, ifc.C}, 3'b000);
        check("reset_async_chg", ifc.abc_changed, 1'b0);
        model_reset();
        steps(n_in_reset);
        n_reset = 1'b1;
    endtask

    initial begin
        int p0;
        int rise;
        int hold;
        logic [2:0] seq_ok;

        ifc.sw = 3'b000;
        model_reset();

        // Reset with sw = 000.
        reset_cycle(3);
        steps(3);
        check("post_reset_abc", {ifc.A, ifc.B, ifc.C}, 3'b000);

        // 000 -> 100: A rises exactly at edge 5, single pulse.
        ifc.sw = 3'b100;
        p0 = pulses;
        rise = -1;
        for (int e = 0; e < 9; e++) begin
            step();
            if (rise < 0 && ifc.A === 1'b1) rise = e;
        end
        check("latency_A", rise, 5);
        check("pulses_A", pulses - p0, 1);

        // B high for 3 sampled cycles only: filtered out.
        ifc.sw = 3'b110;
        p0 = pulses;
        steps(3);
        ifc.sw = 3'b100;
        steps(10);
        check("glitch_B", ifc.B, 1'b0);
        check("pulses_glitch", pulses - p0, 0);

        // Back to 000, then 000 -> 111 on one edge.
        ifc.sw = 3'b000;
        steps(10);
        ifc.sw = 3'b111;
        p0 = pulses;
        rise = -1;
        for (int e = 0; e < 10; e++) begin
            step();
            if (rise < 0 && {ifc.A, ifc.B, ifc.C} === 3'b111) rise = e;
        end
        check("latency_111", rise, 5);
        check("pulses_111", pulses - p0, 1);

        // C pending when reset hits: count discarded, full latency afterwards.
        ifc.sw = 3'b000;
        steps(10);
        ifc.sw = 3'b001;
        steps(2);
        reset_cycle(2);
        check("reset_C", ifc.C, 1'b0);
        rise = -1;
        for (int e = 0; e < 9; e++) begin
            step();
            if (rise < 0 && ifc.C === 1'b1) rise = e;
        end
        check("latency_C_after_reset", rise, 5);

        // Step through all values, 10 cycles each.
        ifc.sw = 3'b000;
        reset_cycle(2);
        p0 = pulses;
        seq_ok = 3'b000;
        for (int v = 0; v < 8; v++) begin
            ifc.sw = 3'(v);
            steps(10);
            check("sweep_value", {ifc.A, ifc.B, ifc.C}, 32'(v));
        end
        check("sweep_pulses", pulses - p0, 7);

        // sw held non-zero through reset release.
        ifc.sw = 3'b101;
        reset_cycle(2);
        p0 = pulses;
        steps(8);
        check("held_through_reset", {ifc.A, ifc.B, ifc.C}, 3'b101);
        check("held_through_reset_pulse", pulses - p0, 1);

        // Random bouncing stimulus against the model.
        for (int k = 0; k < 120; k++) begin
            ifc.sw = 3'($urandom_range(0, 7));
            hold = $urandom_range(1, 7);
            steps(hold);
        end
        steps(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_abc_input_conditioner

// File: doc/abc_input_conditioner.md
ABC_INPUT_CONDITIONER -- requirements
Module: abc_input_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning consecutive clocks a synchronised input must differ from its output before the output updates; legal range >= 1.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port n_reset, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port sw, input, 3 bits: raw, asynchronous, bouncing switch levels; sw[2] feeds A, sw[1] feeds B, sw[0] feeds C.
REQ-005 Port A, output, 1 bit: debounced, registered level of sw[2], driving the downstream truth-table stage.
REQ-006 Port B, output, 1 bit: debounced, registered level of sw[1].
REQ-007 Port C, output, 1 bit: debounced, registered level of sw[0].
REQ-008 Port abc_changed, output, 1 bit: one-cycle pulse marking any change of {A,B,C}.

Function
REQ-009 Each sw bit SHALL pass through a two-flop synchroniser (sync1, then sync2) before any other logic.
REQ-010 Each bit SHALL have its own counter of width $clog2(DEBOUNCE_CYCLES)+1 and a two-state FSM: STABLE (sync2 == output) and PENDING (sync2 != output).
REQ-011 In STABLE, the counter SHALL hold at 0; a clock with sync2 != output SHALL move the FSM to PENDING and set the counter to 1, unless DEBOUNCE_CYCLES == 1.
REQ-012 In PENDING, each clock with sync2 != output SHALL increment the counter.
REQ-013 In PENDING, any clock with sync2 == output (a bounce) SHALL clear the counter and return the FSM to STABLE, with no output change.
REQ-014 At the clock edge where sync2 != output and the counter already equals DEBOUNCE_CYCLES-1, the output bit SHALL take the sync2 value, the counter SHALL clear and the FSM SHALL return to STABLE.
REQ-015 Latency: a raw level first sampled into sync1 at edge k and held SHALL appear on the output at edge k+1+DEBOUNCE_CYCLES.
REQ-016 A raw pulse held for fewer than DEBOUNCE_CYCLES synchronised cycles SHALL never reach the output.
REQ-017 abc_changed SHALL be registered and set at the same edge any of A, B or C changes, then clear at the next edge.
REQ-018 Simultaneous changes on several bits SHALL produce one single-cycle abc_changed pulse.
REQ-019 Back-to-back changes on different bits at consecutive edges SHALL keep abc_changed high for both cycles.
REQ-020 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.

Reset
REQ-021 While n_reset is low, sync1, sync2, counters, A, B, C and abc_changed SHALL be 0, with all FSMs in STABLE, independent of clk.
REQ-022 Reset asserted mid-count SHALL discard the count; after release, the full REQ-015 latency SHALL apply again.
REQ-023 If sw is held non-zero through reset release, the outputs SHALL reach sw after the REQ-015 latency and SHALL pulse abc_changed at that edge.

Structure
REQ-024 Package abc_pkg SHALL hold the FSM state enum (STABLE, PENDING) and the constant DEFAULT_DEBOUNCE_CYCLES = 50000.
REQ-025 Sub-module debounce_bit (synchroniser, counter, FSM, one output bit) SHALL be instantiated three times; the top SHALL only wire the bits and generate abc_changed.

Verification (DEBOUNCE_CYCLES = 4)
REQ-026 Reset with sw=000 -> {A,B,C}=000 and abc_changed=0 during and after reset.
REQ-027 sw 000->100, first sampled at edge 0 and held -> A=1 at edge 5, abc_changed high only between edges 5 and 6.
REQ-028 sw[1] high for 3 sampled cycles, then low -> B stays 0 and abc_changed never asserts.
REQ-029 sw 000->111 on one edge -> A, B and C rise at the same edge with a single one-cycle abc_changed pulse.
REQ-030 sw=001 held for 2 cycles, then n_reset pulsed low, then released -> C=0 during reset; C=1 exactly 5 edges after the first post-release sample.
REQ-031 sw stepped 000..111, each value held for 10 cycles -> {A,B,C} tracks every value in order, with exactly 7 abc_changed pulses.
